// File: rtl/fp_add_scheduler_if.sv
// Bundle of issue-port, datapath-control and response signals for fp_add_scheduler.
// master = surrounding issue logic / datapath / consumer; slave = the scheduler.
interface fp_add_scheduler_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_op1;
    logic [1:0][31:0] req_op2;
    logic [1:0]       req_sub;

    logic [31:0]      dp_op1;
    logic [31:0]      dp_op2;
    logic             dp_sub;
    logic             dp_align_en;
    logic             dp_add_en;
    logic             dp_norm_en;
    logic             dp_sign_en;
    logic             dp_norm_done;
    logic [31:0]      dp_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [31:0]      rsp_result;
    logic             rsp_err;
    logic             busy;

    modport master (
        output req_valid, req_op1, req_op2, req_sub, dp_norm_done, dp_result, rsp_ready,
        input  req_ready, dp_op1, dp_op2, dp_sub, dp_align_en, dp_add_en, dp_norm_en,
               dp_sign_en, rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op1, req_op2, req_sub, dp_norm_done, dp_result, rsp_ready,
        output req_ready, dp_op1, dp_op2, dp_sub, dp_align_en, dp_add_en, dp_norm_en,
               dp_sign_en, rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );
endinterface

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sequencing a shared FP add datapath ALIGN->ADD->NORM->SIGN.
// Optional macro FP_SCHED_ZERO_BYPASS_EN: zero-operand requests skip the datapath.
module fp_add_scheduler #(
    parameter int unsigned NORM_MAX_CYCLES = 24
) (
    input logic               clk,
    input logic               rst,
    fp_add_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_SIGN,
        S_DONE
    } state_t;

    localparam logic [4:0] NORM_LAST = 5'(NORM_MAX_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last_grant;
    logic [4:0]  r_norm_cnt;
    logic [31:0] r_dp_op1;
    logic [31:0] r_dp_op2;
    logic        r_dp_sub;
    logic        r_rsp_id;
    logic [31:0] r_rsp_result;
    logic        r_rsp_err;

    logic        w_any;
    logic        w_grant;
    logic        w_accept;
    logic [31:0] w_sel_op1;
    logic [31:0] w_sel_op2;
    logic        w_sel_sub;
    logic        w_norm_timeout;
    logic        w_bypass;
    logic [31:0] w_bypass_result;

    // Alternate on contention, otherwise serve whichever requester is asking.
    assign w_any     = |bus.req_valid;
    assign w_grant   = (bus.req_valid == 2'b11) ? ~r_last_grant : bus.req_valid[1];
    assign w_accept  = (r_state == S_IDLE) && w_any;
    assign w_sel_op1 = bus.req_op1[w_grant];
    assign w_sel_op2 = bus.req_op2[w_grant];
    assign w_sel_sub = bus.req_sub[w_grant];

    // A normalizer that reports done on its last allowed cycle is not a timeout.
    assign w_norm_timeout = !bus.dp_norm_done && (r_norm_cnt == NORM_LAST);

`ifdef FP_SCHED_ZERO_BYPASS_EN
    logic w_op1_zero;
    logic w_op2_zero;

    assign w_op1_zero = (w_sel_op1[30:0] == 31'b0);
    assign w_op2_zero = (w_sel_op2[30:0] == 31'b0);
    assign w_bypass   = w_op1_zero || w_op2_zero;

    always_comb begin
        w_bypass_result = w_sel_op1;
        if (w_op1_zero && w_op2_zero) begin
            w_bypass_result = {w_sel_op1[31] & (w_sel_op2[31] ^ w_sel_sub), 31'b0};
        end else if (w_op1_zero) begin
            w_bypass_result = {w_sel_op2[31] ^ w_sel_sub, w_sel_op2[30:0]};
        end
    end
`else
    assign w_bypass        = 1'b0;
    assign w_bypass_result = 32'b0;
`endif

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        w_next_state    = r_state;
        bus.req_ready   = 2'b00;
        bus.dp_align_en = 1'b0;
        bus.dp_add_en   = 1'b0;
        bus.dp_norm_en  = 1'b0;
        bus.dp_sign_en  = 1'b0;
        bus.rsp_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    bus.req_ready[w_grant] = 1'b1;
                    w_next_state = w_bypass ? S_DONE : S_ALIGN;
                end
            end
            S_ALIGN: begin
                bus.dp_align_en = 1'b1;
                w_next_state    = S_ADD;
            end
            S_ADD: begin
                bus.dp_add_en = 1'b1;
                w_next_state  = S_NORM;
            end
            S_NORM: begin
                bus.dp_norm_en = 1'b1;
                if (bus.dp_norm_done || (r_norm_cnt == NORM_LAST)) begin
                    w_next_state = S_SIGN;
                end
            end
            S_SIGN: begin
                bus.dp_sign_en = 1'b1;
                w_next_state   = S_DONE;
            end
            S_DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_norm_cnt   <= 5'd0;
            r_dp_op1     <= 32'b0;
            r_dp_op2     <= 32'b0;
            r_dp_sub     <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 32'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dp_op1     <= w_sel_op1;
                r_dp_op2     <= w_sel_op2;
                r_dp_sub     <= w_sel_sub;
                r_rsp_id     <= w_grant;
                r_last_grant <= w_grant;
                r_rsp_err    <= 1'b0;
                if (w_bypass) begin
                    r_rsp_result <= w_bypass_result;
                end
            end

            if (r_state == S_ADD) begin
                r_norm_cnt <= 5'd0;
            end else if (r_state == S_NORM) begin
                r_norm_cnt <= r_norm_cnt + 5'd1;
                if (w_norm_timeout) begin
                    r_rsp_err <= 1'b1;
                end
            end

            if (r_state == S_SIGN) begin
                r_rsp_result <= bus.dp_result;
            end
        end
    end

    assign bus.dp_op1     = r_dp_op1;
    assign bus.dp_op2     = r_dp_op2;
    assign bus.dp_sub     = r_dp_sub;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Randomized self-checking bench for fp_add_scheduler against a transaction-level model.
// The bench doubles as the datapath: it answers dp_norm_done and dp_result from the strobes.
module tb_fp_add_scheduler;

    localparam int NORM_MAX = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_add_scheduler_if ifc ();

    fp_add_scheduler #(.NORM_MAX_CYCLES(NORM_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Requester and consumer stimulus
    logic [1:0]  v_valid;
    logic [31:0] v_op1 [2];
    logic [31:0] v_op2 [2];
    logic [1:0]  v_sub;
    logic        v_rsp_ready;
    int          next_target;
    logic [31:0] next_result;

    // Transaction model: at most one operation outstanding
    bit          m_busy;
    logic        m_last;
    int          m_ready_cyc;
    logic        m_id;
    logic [31:0] m_result;
    logic        m_err;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic        m_sub;
    int          m_target;
    logic [31:0] m_dp_result;
    int          norm_seen;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit is_zero(input logic [31:0] x);
        return x[30:0] == 31'b0;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        x = $urandom;
        if ($urandom_range(3) == 0) x = {x[31], 31'b0};
        return x;
    endfunction

    function automatic logic [31:0] rand_nonzero();
        logic [31:0] x;
        x = $urandom;
        return x | 32'h3F80_0000;
    endfunction

    task automatic model_reset();
        m_busy    = 1'b0;
        m_last    = 1'b1;
        norm_seen = 0;
        m_target  = 1;
    endtask

    task automatic model_accept(input logic g);
        bit byp;
        int norm_cycles;
        byp   = 1'b0;
        m_id  = g;
        m_op1 = v_op1[g];
        m_op2 = v_op2[g];
        m_sub = v_sub[g];
`ifdef FP_SCHED_ZERO_BYPASS_EN
        byp = is_zero(m_op1) || is_zero(m_op2);
`endif
        if (byp) begin
            m_err       = 1'b0;
            m_ready_cyc = cyc + 1;
            m_target    = 1;
            if (is_zero(m_op1) && is_zero(m_op2))
                m_result = {m_op1[31] & (m_op2[31] ^ m_sub), 31'b0};
            else if (is_zero(m_op2))
                m_result = m_op1;
            else
                m_result = {m_op2[31] ^ m_sub, m_op2[30:0]};
        end else begin
            m_target    = next_target;
            m_dp_result = next_result;
            m_result    = next_result;
            m_err       = (next_target > NORM_MAX);
            norm_cycles = (next_target > NORM_MAX) ? NORM_MAX : next_target;
            m_ready_cyc = cyc + 4 + norm_cycles;
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, advance the model.
    task automatic step();
        logic [1:0] exp_ready;
        logic       g;
        bit         exp_valid;
        @(negedge clk);
        if (ifc.dp_norm_en) begin
            ifc.dp_norm_done = (norm_seen == m_target - 1);
            norm_seen++;
        end else begin
            ifc.dp_norm_done = 1'($urandom_range(1));
            norm_seen = 0;
        end
        ifc.dp_result = ifc.dp_sign_en ? m_dp_result : $urandom;
        ifc.req_valid = v_valid;
        for (int i = 0; i < 2; i++) begin
            ifc.req_op1[i] = v_op1[i];
            ifc.req_op2[i] = v_op2[i];
        end
        ifc.req_sub   = v_sub;
        ifc.rsp_ready = v_rsp_ready;
        #1;
        g         = (v_valid == 2'b11) ? ~m_last : v_valid[1];
        exp_ready = (!m_busy && (|v_valid)) ? (2'b01 << g) : 2'b00;
        exp_valid = m_busy && (cyc >= m_ready_cyc);
        check("req_ready", ifc.req_ready, exp_ready);
        check("busy", ifc.busy, m_busy);
        check("rsp_valid", ifc.rsp_valid, exp_valid);
        check("strobe_onehot0",
              $onehot0({ifc.dp_align_en, ifc.dp_add_en, ifc.dp_norm_en, ifc.dp_sign_en}), 1);
        if (exp_valid) begin
            check("rsp_id", ifc.rsp_id, m_id);
            check("rsp_result", ifc.rsp_result, m_result);
            check("rsp_err", ifc.rsp_err, m_err);
        end
        if (ifc.dp_align_en) begin
            check("dp_op1", ifc.dp_op1, m_op1);
            check("dp_op2", ifc.dp_op2, m_op2);
            check("dp_sub", ifc.dp_sub, m_sub);
        end
        if (exp_valid && v_rsp_ready) begin
            m_busy = 1'b0;
        end else if (!m_busy && (|v_valid)) begin
            model_accept(g);
            m_busy     = 1'b1;
            m_last     = g;
            v_valid[g] = 1'b0;
        end
        cyc++;
    endtask

    task automatic randomize_reqs();
        for (int i = 0; i < 2; i++) begin
            if (!v_valid[i] && ($urandom_range(1) == 1)) begin
                v_valid[i] = 1'b1;
                v_op1[i]   = rand_op();
                v_op2[i]   = rand_op();
                v_sub[i]   = 1'($urandom_range(1));
            end
        end
        v_rsp_ready = ($urandom_range(3) != 0);
        next_target = ($urandom_range(7) == 0) ? 25 + $urandom_range(10) : 1 + $urandom_range(3);
        next_result = $urandom;
    endtask

    initial begin
        bit seen_norm;
        v_valid          = 2'b00;
        v_sub            = 2'b00;
        v_op1[0]         = 32'b0;
        v_op1[1]         = 32'b0;
        v_op2[0]         = 32'b0;
        v_op2[1]         = 32'b0;
        v_rsp_ready      = 1'b0;
        next_target      = 1;
        next_result      = 32'b0;
        m_dp_result      = 32'b0;
        ifc.req_valid    = 2'b00;
        ifc.req_op1      = '0;
        ifc.req_op2      = '0;
        ifc.req_sub      = 2'b00;
        ifc.dp_norm_done = 1'b0;
        ifc.dp_result    = 32'b0;
        ifc.rsp_ready    = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", ifc.busy, 0);
        check("rst_rsp_valid", ifc.rsp_valid, 0);
        check("rst_rsp_result", ifc.rsp_result, 0);
        check("rst_rsp_id", ifc.rsp_id, 0);
        check("rst_rsp_err", ifc.rsp_err, 0);
        check("rst_dp_op1", ifc.dp_op1, 0);
        check("rst_dp_op2", ifc.dp_op2, 0);
        check("rst_dp_sub", ifc.dp_sub, 0);
        check("rst_strobes", {ifc.dp_align_en, ifc.dp_add_en, ifc.dp_norm_en, ifc.dp_sign_en}, 0);
        check("rst_req_ready", ifc.req_ready, 0);
        rst = 1'b0;

        // 1.0 + 2.0, normalizer done on the first NORM cycle
        v_valid     = 2'b01;
        v_op1[0]    = 32'h3F80_0000;
        v_op2[0]    = 32'h4000_0000;
        v_sub[0]    = 1'b0;
        v_rsp_ready = 1'b1;
        next_target = 1;
        next_result = 32'h4040_0000;
        repeat (8) step();

        // Normalizer never finishes: forced exit with error flag
        v_valid     = 2'b10;
        v_op1[1]    = rand_nonzero();
        v_op2[1]    = rand_nonzero();
        v_sub[1]    = 1'b1;
        next_target = 100;
        next_result = $urandom;
        repeat (32) step();

        // Both requesters held valid: grants alternate
        next_target = 1;
        repeat (30) begin
            for (int i = 0; i < 2; i++) begin
                if (!v_valid[i]) begin
                    v_op1[i] = rand_nonzero();
                    v_op2[i] = rand_nonzero();
                    v_sub[i] = 1'($urandom_range(1));
                end
            end
            v_valid     = 2'b11;
            next_result = $urandom;
            step();
        end
        v_valid = 2'b00;
        repeat (8) step();

        // Backpressure: result must stay put while requester 1 waits
        v_valid     = 2'b01;
        v_op1[0]    = rand_nonzero();
        v_op2[0]    = rand_nonzero();
        v_rsp_ready = 1'b0;
        next_target = 2;
        next_result = $urandom;
        step();
        v_valid[1]  = 1'b1;
        v_op1[1]    = rand_nonzero();
        v_op2[1]    = rand_nonzero();
        repeat (16) step();
        v_rsp_ready = 1'b1;
        next_result = $urandom;
        step();
        step();
        repeat (10) step();

        // Reset while the normalizer is running
        v_valid     = 2'b01;
        v_op1[0]    = rand_nonzero();
        v_op2[0]    = rand_nonzero();
        next_target = 100;
        seen_norm   = 1'b0;
        for (int k = 0; k < 10 && !seen_norm; k++) begin
            step();
            seen_norm = ifc.dp_norm_en;
        end
        check("reach_norm_before_reset", seen_norm, 1);
        rst = 1'b1;
        #1;
        check("midop_rst_busy", ifc.busy, 0);
        check("midop_rst_rsp_valid", ifc.rsp_valid, 0);
        model_reset();
        v_valid = 2'b00;
        @(negedge clk);
        #2;
        rst = 1'b0;
        v_valid     = 2'b11;
        v_op1[0]    = rand_nonzero();
        v_op2[0]    = rand_nonzero();
        v_op1[1]    = rand_nonzero();
        v_op2[1]    = rand_nonzero();
        next_target = 1;
        next_result = $urandom;
        step();
        check("post_reset_grant", ifc.req_ready, 2'b01);
        v_valid = 2'b00;
        repeat (8) step();

        // Signed-zero operands (short-circuit when the bypass is built in)
        v_valid     = 2'b01;
        v_op1[0]    = 32'h8000_0000;
        v_op2[0]    = 32'h0000_0000;
        v_sub[0]    = 1'b1;
        next_result = $urandom;
        repeat (8) step();
        v_valid     = 2'b01;
        v_op1[0]    = 32'h0000_0000;
        v_op2[0]    = 32'h8000_0000;
        v_sub[0]    = 1'b0;
        next_result = $urandom;
        repeat (8) step();

        // Random traffic
        repeat (1500) begin
            randomize_reqs();
            step();
        end

        // Drain
        v_valid     = 2'b00;
        v_rsp_ready = 1'b1;
        repeat (40) step();
        check("drained_busy", ifc.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
